// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Initiator side of the ALU operand/control interface. Takes one decoded
//   instruction (opcode, funct, two operands) per request handshake, maps it
//   to a 3-bit ALU control code and drives the ALU operand ports for the op
//   latency (MUL_LAT cycles for MUL, one cycle otherwise). It then captures
//   the ALU result and zero flag and returns them on a response handshake.
//   Only one request is in flight at a time.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. in_ready is high only in IDLE. out_valid is high only in
//   DONE, and out_* stay stable until the response is taken. The next
//   request cannot be accepted in the same cycle the response is taken.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             request handshake
//   opcode, funct, op_a, op_b     request payload
//   alu_scrA, alu_scrB, alu_ctrl  to the combinational ALU (zero when idle)
//   alu_result, alu_zero          from the ALU
//   out_valid/out_ready           response handshake
//   out_result, out_zero,
//   out_branch, out_illegal       response payload
//   dbg_state                     current FSM state (0 IDLE, 1 EXEC, 2 DONE)
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_scrA,
    output logic [WIDTH-1:0] alu_scrB,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_branch,
    output logic             out_illegal,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LP_AND = 3'b000;
    localparam logic [2:0] LP_OR  = 3'b001;
    localparam logic [2:0] LP_ADD = 3'b010;
    localparam logic [2:0] LP_SUB = 3'b100;
    localparam logic [2:0] LP_MUL = 3'b101;
    localparam logic [2:0] LP_SLT = 3'b110;

    // MUL holds operands MUL_LAT cycles: count down from MUL_LAT-1 to 0.
    localparam logic [3:0] LP_MUL_CNT = 4'(MUL_LAT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_ctrl;
    logic               r_is_beq;
    logic [WIDTH-1:0]   r_out_result;
    logic               r_out_zero;
    logic               r_out_branch;
    logic               r_out_illegal;

    logic [2:0]         w_dec_ctrl;
    logic               w_dec_legal;
    logic               w_dec_is_beq;
    logic               w_dec_is_mul;
    logic               w_accept;
    logic               w_capture;
    logic               w_cnt_dec;

    // -----------------------------------------------------------------------
    // Instruction decode (funct only matters for R-type)
    // -----------------------------------------------------------------------
    always_comb begin
        w_dec_ctrl   = LP_AND;
        w_dec_legal  = 1'b1;
        w_dec_is_beq = 1'b0;
        w_dec_is_mul = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: w_dec_ctrl = LP_ADD;
                    6'b100010: w_dec_ctrl = LP_SUB;
                    6'b100100: w_dec_ctrl = LP_AND;
                    6'b100101: w_dec_ctrl = LP_OR;
                    6'b101010: w_dec_ctrl = LP_SLT;
                    6'b011000: begin
                        w_dec_ctrl   = LP_MUL;
                        w_dec_is_mul = 1'b1;
                    end
                    default:   w_dec_legal = 1'b0;
                endcase
            end
            6'b100011: w_dec_ctrl = LP_ADD;   // LW address add
            6'b101011: w_dec_ctrl = LP_ADD;   // SW address add
            6'b001000: w_dec_ctrl = LP_ADD;   // ADDI
            6'b001100: w_dec_ctrl = LP_AND;   // ANDI
            6'b001101: w_dec_ctrl = LP_OR;    // ORI
            6'b000100: begin                  // BEQ compares by subtraction
                w_dec_ctrl   = LP_SUB;
                w_dec_is_beq = 1'b1;
            end
            default:   w_dec_legal = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        alu_scrA     = '0;
        alu_scrB     = '0;
        alu_ctrl     = 3'b000;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    // Illegal ops skip EXEC so the ALU is never driven.
                    w_next_state = w_dec_legal ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                alu_scrA = r_a;
                alu_scrB = r_b;
                alu_ctrl = r_ctrl;
                if (r_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request latch, latency counter and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 4'd0;
            r_a           <= '0;
            r_b           <= '0;
            r_ctrl        <= 3'b000;
            r_is_beq      <= 1'b0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_branch  <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a           <= op_a;
                r_b           <= op_b;
                r_ctrl        <= w_dec_ctrl;
                r_is_beq      <= w_dec_is_beq;
                r_cnt         <= w_dec_is_mul ? LP_MUL_CNT : 4'd0;
                // Clear the previous response; an illegal op reports only the flag.
                r_out_result  <= '0;
                r_out_zero    <= 1'b0;
                r_out_branch  <= 1'b0;
                r_out_illegal <= ~w_dec_legal;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_out_result  <= alu_result;
                r_out_zero    <= alu_zero;
                r_out_branch  <= r_is_beq & alu_zero;
                r_out_illegal <= 1'b0;
            end
        end
    end

    assign out_result  = r_out_result;
    assign out_zero    = r_out_zero;
    assign out_branch  = r_out_branch;
    assign out_illegal = r_out_illegal;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 4;
  localparam int NVEC    = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_scrA;
  logic [WIDTH-1:0] alu_scrB;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_branch;
  logic             out_illegal;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  alu_issue_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct      (funct),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_scrA   (alu_scrA),
    .alu_scrB   (alu_scrB),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_branch (out_branch),
    .out_illegal(out_illegal),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Combinational ALU the controller talks to (unsigned SLT)
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000:  alu_result = alu_scrA & alu_scrB;
      3'b001:  alu_result = alu_scrA | alu_scrB;
      3'b010:  alu_result = alu_scrA + alu_scrB;
      3'b100:  alu_result = alu_scrA - alu_scrB;
      3'b101:  alu_result = alu_scrA * alu_scrB;
      3'b110:  alu_result = (alu_scrA < alu_scrB) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        br;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vec[NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Driver: issue one request, follow it through EXEC, check the response.
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    opcode   = v.opc;
    funct    = v.fn;
    op_a     = v.a;
    op_b     = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble the request bus: the DUT must use its latched copy.
    opcode   = 6'($urandom_range(0, 63));
    funct    = 6'($urandom_range(0, 63));
    op_a     = $urandom;
    op_b     = $urandom;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      chk($sformatf("v%0d_exec_ctrl", idx), {29'd0, alu_ctrl}, {29'd0, v.ctrl});
      chk($sformatf("v%0d_exec_a", idx), alu_scrA, v.a);
      chk($sformatf("v%0d_exec_b", idx), alu_scrB, v.b);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_result", idx), out_result, v.res);
    chk($sformatf("v%0d_zero", idx), {31'd0, out_zero}, {31'd0, v.z});
    chk($sformatf("v%0d_branch", idx), {31'd0, out_branch}, {31'd0, v.br});
    chk($sformatf("v%0d_illegal", idx), {31'd0, out_illegal}, {31'd0, v.ill});
    chk($sformatf("v%0d_done_ctrl", idx), {29'd0, alu_ctrl}, 32'd0);
    chk($sformatf("v%0d_done_a", idx), alu_scrA, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d_post_valid", idx), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d_post_ready", idx), {31'd0, in_ready}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int accepts;
    int dones;
    logic seen_valid;
    vec_t v;

    //            opc    fn     a             b             ctrl    res           z     br    ill   lat
    vec[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        3'b010, 32'd12,       1'b0, 1'b0, 1'b0, 2}; // ADD
    vec[1]  = '{6'h00, 6'h22, 32'd10,       32'd3,        3'b100, 32'd7,        1'b0, 1'b0, 1'b0, 2}; // SUB
    vec[2]  = '{6'h00, 6'h24, 32'h0000F0F0, 32'h00000FF0, 3'b000, 32'h000000F0, 1'b0, 1'b0, 1'b0, 2}; // AND
    vec[3]  = '{6'h00, 6'h25, 32'h0000F000, 32'h0000000F, 3'b001, 32'h0000F00F, 1'b0, 1'b0, 1'b0, 2}; // OR
    vec[4]  = '{6'h00, 6'h2A, 32'd3,        32'd5,        3'b110, 32'd1,        1'b0, 1'b0, 1'b0, 2}; // SLT true
    vec[5]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        3'b110, 32'd0,        1'b1, 1'b0, 1'b0, 2}; // SLT unsigned
    vec[6]  = '{6'h00, 6'h18, 32'd6,        32'd7,        3'b101, 32'd42,       1'b0, 1'b0, 1'b0, 5}; // MUL
    vec[7]  = '{6'h00, 6'h18, 32'h00010000, 32'h00010000, 3'b101, 32'd0,        1'b1, 1'b0, 1'b0, 5}; // MUL wrap
    vec[8]  = '{6'h23, 6'h3F, 32'h00001000, 32'd4,        3'b010, 32'h00001004, 1'b0, 1'b0, 1'b0, 2}; // LW
    vec[9]  = '{6'h2B, 6'h00, 32'd8,        32'hFFFFFFF8, 3'b010, 32'd0,        1'b1, 1'b0, 1'b0, 2}; // SW
    vec[10] = '{6'h08, 6'h3F, 32'd2,        32'd3,        3'b010, 32'd5,        1'b0, 1'b0, 1'b0, 2}; // ADDI
    vec[11] = '{6'h0C, 6'h00, 32'h000000FF, 32'h0000000F, 3'b000, 32'h0000000F, 1'b0, 1'b0, 1'b0, 2}; // ANDI
    vec[12] = '{6'h0D, 6'h11, 32'h000000F0, 32'h0000000F, 3'b001, 32'h000000FF, 1'b0, 1'b0, 1'b0, 2}; // ORI
    vec[13] = '{6'h04, 6'h20, 32'h00001234, 32'h00001234, 3'b100, 32'd0,        1'b1, 1'b1, 1'b0, 2}; // BEQ taken
    vec[14] = '{6'h04, 6'h00, 32'd3,        32'd4,        3'b100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2}; // BEQ not taken
    vec[15] = '{6'h3F, 6'h20, 32'd1,        32'd1,        3'b000, 32'd0,        1'b0, 1'b0, 1'b1, 1}; // illegal opcode
    vec[16] = '{6'h08, 6'h00, 32'd9,        32'd9,        3'b010, 32'd18,       1'b0, 1'b0, 1'b0, 2}; // ADDI, nonzero before illegal
    vec[17] = '{6'h00, 6'h21, 32'd4,        32'd4,        3'b000, 32'd0,        1'b0, 1'b0, 1'b1, 1}; // R-type ADDU not in table
    vec[18] = '{6'h00, 6'h00, 32'd4,        32'd4,        3'b000, 32'd0,        1'b0, 1'b0, 1'b1, 1}; // R-type funct 0
    vec[19] = '{6'h02, 6'h20, 32'd4,        32'd4,        3'b000, 32'd0,        1'b0, 1'b0, 1'b1, 1}; // J not supported

    // Reset
    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = 6'd0;
    funct     = 6'd0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("rst_alu_a", alu_scrA, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      run_op(vec[i], i);
    end

    // Backpressure: ADD 1+1 response held for 5 cycles, new request ignored.
    in_valid = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h20;
    op_a     = 32'd1;
    op_b     = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 2);
    in_valid = 1'b1;
    funct    = 6'h22;
    op_a     = 32'd9;
    op_b     = 32'd1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_result_final", out_result, 32'd2);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_post_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_post_ready", {31'd0, in_ready}, 32'd1);
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("bp_ignored_req", {31'd0, seen_valid}, 32'd0);

    // Back-to-back with out_ready held high: one issue every 3 cycles.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    op_a      = 32'd1;
    op_b      = 32'd2;
    accepts   = 0;
    dones     = 0;
    for (int c = 0; c < 9; c++) begin
      if (in_ready) accepts++;
      if (out_valid) begin
        dones++;
        chk("b2b_result", out_result, 32'd3);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", accepts, 3);
    chk("b2b_dones", dones, 3);

    // Reset pulsed in the second EXEC cycle of a MUL.
    in_valid = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h18;
    op_a     = 32'd6;
    op_b     = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mrst_exec1_ctrl", {29'd0, alu_ctrl}, 32'd5);
    @(negedge clk);
    chk("mrst_exec2_ctrl", {29'd0, alu_ctrl}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("mrst_alu_a", alu_scrA, 32'd0);
    chk("mrst_alu_b", alu_scrB, 32'd0);
    chk("mrst_out_result", out_result, 32'd0);
    seen_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("mrst_dropped", {31'd0, seen_valid}, 32'd0);
    v = '{6'h00, 6'h22, 32'd9, 32'd9, 3'b100, 32'd0, 1'b1, 1'b0, 1'b0, 2};
    run_op(v, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
